// File: rtl/ahb_cfg_manager.sv
// Single-outstanding AHB-Lite manager turning simple word commands into SINGLE NONSEQ transfers
// into a register window, with data-phase wait timeout and registered response reporting.
module ahb_cfg_manager #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // Command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_offset,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  // Response side
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // AHB manager outputs
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic [3:0]  HWSTRB,
  // AHB manager inputs
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [8:0] TimeoutCnt  = 9'(TIMEOUT);

  state_e      state_q;
  logic [31:0] wdata_q;
  logic [8:0]  wait_cnt_q;
  logic [8:0]  wait_inc;

  assign wait_inc = wait_cnt_q + 9'd1;

  // Single-beat word transfers only.
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      HSEL        <= 1'b0;
      HADDR       <= BASE_ADDR;
      HTRANS      <= TransIdle;
      HWRITE      <= 1'b0;
      HWDATA      <= '0;
      HWSTRB      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // cmd_ready is low for one IDLE cycle after reset and after each response.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            state_q   <= StAddr;
            wdata_q   <= cmd_wdata;
            HSEL      <= 1'b1;
            HTRANS    <= TransNonseq;
            HWRITE    <= cmd_write;
            HADDR     <= BASE_ADDR + {22'd0, cmd_offset, 2'b00};
            HWSTRB    <= cmd_strb;
          end
        end
        StAddr: begin
          if (HREADY) begin
            state_q    <= StData;
            wait_cnt_q <= '0;
            HSEL       <= 1'b0;
            HTRANS     <= TransIdle;
            HWDATA     <= HWRITE ? wdata_q : 32'd0;
          end
        end
        StData: begin
          if (HREADY) begin
            state_q     <= StIdle;
            rsp_valid   <= 1'b1;
            rsp_err     <= HRESP;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!HWRITE && !HRESP) ? HRDATA : 32'd0;
            HWDATA      <= '0;
          end else begin
            // First cycle of a two-cycle ERROR response counts as an ordinary wait.
            wait_cnt_q <= wait_inc;
            if (wait_inc == TimeoutCnt) begin
              state_q     <= StIdle;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
              HWDATA      <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_cfg_manager.sv
// Self-checking bench for ahb_cfg_manager: directed vector table, hand-written reset and
// back-to-back sequences, and randomized transfers checked against a transaction-level model.
module tb_ahb_cfg_manager;

  localparam logic [31:0] Base = 32'h8000_0000;
  localparam int          To   = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_offset;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HWSTRB;
  logic        HREADY, HRESP;

  ahb_cfg_manager #(
    .BASE_ADDR(Base),
    .TIMEOUT  (To)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_offset (cmd_offset),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HWSTRB     (HWSTRB),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int accept_cyc;

  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic        write;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw;        // address-phase wait cycles
    int          dw;        // data-phase wait cycles
    logic        err;       // subordinate answers ERROR
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t b2b[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: address arithmetic, timeout after To waits, error/read rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r          = v;
    r.exp_addr = Base + (32'(v.off) * 32'd4);
    r.exp_to   = (v.dw >= To);
    r.exp_err  = r.exp_to || v.err;
    r.exp_rdata = (r.exp_err || v.write) ? 32'd0 : v.rdata;
    return r;
  endfunction

  task automatic busy_drive(input bit hold);
    logic [31:0] r;
    if (!hold) begin
      r          = $urandom;
      cmd_valid  = r[0];
      cmd_write  = r[1];
      cmd_strb   = r[7:4];
      cmd_offset = r[15:8];
      cmd_wdata  = $urandom;
    end
  endtask

  // Starts at a negedge with cmd_ready expected high; ends at the negedge after the response.
  task automatic run_txn(input vec_t v, input bit hold);
    int nd;
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_write  = v.write;
    cmd_offset = v.off;
    cmd_wdata  = v.wdata;
    cmd_strb   = v.strb;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    @(negedge HCLK);
    accept_cyc = cyc;
    for (int k = 0; k <= v.aw; k++) begin
      chk("addr_htrans", 32'(HTRANS), 32'd2);
      chk("addr_hsel", 32'(HSEL), 32'd1);
      chk("addr_haddr", HADDR, v.exp_addr);
      chk("addr_hwrite", 32'(HWRITE), 32'(v.write));
      chk("addr_hwstrb", 32'(HWSTRB), 32'(v.strb));
      chk("addr_cmd_ready", 32'(cmd_ready), 32'd0);
      busy_drive(hold);
      HREADY = (k == v.aw);
      HRESP  = 1'b0;
      HRDATA = $urandom;
      @(negedge HCLK);
    end
    nd = (v.dw >= To) ? To : v.dw + 1;
    for (int k = 0; k < nd; k++) begin
      chk("data_htrans", 32'(HTRANS), 32'd0);
      chk("data_hsel", 32'(HSEL), 32'd0);
      chk("data_hwdata", HWDATA, v.write ? v.wdata : 32'd0);
      chk("data_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("data_cmd_ready", 32'(cmd_ready), 32'd0);
      busy_drive(hold);
      if (k < v.dw) begin
        HREADY = 1'b0;
        HRESP  = v.err && (k == v.dw - 1);
        HRDATA = $urandom;
      end else begin
        HREADY = 1'b1;
        HRESP  = v.err;
        HRDATA = v.rdata;
      end
      @(negedge HCLK);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
    if (!v.exp_to) chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
    busy_drive(hold);
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = $urandom;
    @(negedge HCLK);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_err_hold", 32'(rsp_err), 32'(v.exp_err));
    chk("post_to_hold", 32'(rsp_timeout), 32'(v.exp_to));
    if (!v.exp_to) chk("post_rdata_hold", rsp_rdata, v.exp_rdata);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   prev;
    vec_t rv;
    logic [31:0] r;

    // Directed vectors with hand-derived expectations.
    vecs[0] = '{1'b1, 8'd1, 32'h8, 4'hF, 0, 0, 1'b0, 32'h0,
                32'h8000_0004, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 8'd2, 32'h0, 4'hF, 0, 2, 1'b0, 32'h48,
                32'h8000_0008, 1'b0, 1'b0, 32'h48};
    vecs[2] = '{1'b1, 8'd3, 32'hDEAD, 4'h3, 0, 1, 1'b1, 32'h0,
                32'h8000_000C, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 8'd5, 32'h0, 4'hF, 1, 10, 1'b0, 32'h1234,
                32'h8000_0014, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 8'hFF, 32'h0, 4'h1, 2, 0, 1'b0, 32'hCAFE_BABE,
                32'h8000_03FC, 1'b0, 1'b0, 32'hCAFE_BABE};
    vecs[5] = '{1'b0, 8'h10, 32'h0, 4'hF, 0, 0, 1'b1, 32'h5555_5555,
                32'h8000_0040, 1'b1, 1'b0, 32'h0};
    b2b[0] = '{1'b1, 8'd0, 32'h100, 4'hF, 0, 0, 1'b0, 32'h0,
               32'h8000_0000, 1'b0, 1'b0, 32'h0};
    b2b[1] = '{1'b1, 8'd1, 32'h8, 4'hF, 0, 0, 1'b0, 32'h0,
               32'h8000_0004, 1'b0, 1'b0, 32'h0};
    b2b[2] = '{1'b1, 8'd2, 32'd72, 4'hF, 0, 0, 1'b0, 32'h0,
               32'h8000_0008, 1'b0, 1'b0, 32'h0};
    b2b[3] = '{1'b1, 8'd3, 32'h1, 4'hF, 0, 0, 1'b0, 32'h0,
               32'h8000_000C, 1'b0, 1'b0, 32'h0};

    HRESETn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_offset = '0;
    cmd_wdata  = '0;
    cmd_strb   = '0;
    HRDATA     = '0;
    HREADY     = 1'b1;
    HRESP      = 1'b0;

    repeat (2) @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hsel", 32'(HSEL), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_haddr", HADDR, Base);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hwstrb", 32'(HWSTRB), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("hsize", 32'(HSIZE), 32'd2);
    chk("hburst", 32'(HBURST), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

    // Back-to-back writes with cmd_valid held: acceptance, 3-cycle latency, one ready cycle.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_txn(b2b[i], 1'b1);
      if (i > 0) chk("b2b_gap", 32'(accept_cyc - prev), 32'd4);
      prev = accept_cyc;
    end

    // Reset asserted while the address phase is on the bus.
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_offset = 8'd6;
    cmd_wdata  = 32'hA5A5_A5A5;
    cmd_strb   = 4'hF;
    HREADY     = 1'b0;
    @(negedge HCLK);
    chk("rstmid_in_addr", 32'(HTRANS), 32'd2);
    #2 HRESETn = 1'b0;
    #1;
    chk("rstmid_htrans", 32'(HTRANS), 32'd0);
    chk("rstmid_hsel", 32'(HSEL), 32'd0);
    chk("rstmid_haddr", HADDR, Base);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rstmid_hwstrb", 32'(HWSTRB), 32'd0);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("rstmid_held_ready", 32'(cmd_ready), 32'd0);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rstmid_idle_bus", 32'(HTRANS), 32'd0);
      chk("rstmid_ready", 32'(cmd_ready), 32'd1);
    end

    // Randomized transfers against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      r        = $urandom;
      rv.write = r[0];
      rv.err   = (r[3:2] == 2'b00);
      rv.strb  = r[7:4];
      rv.off   = r[15:8];
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.aw    = int'($urandom_range(0, 2));
      rv.dw    = int'($urandom_range(0, 6));
      rv       = model(rv);
      run_txn(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
